condlogic_mc: RTL and testbench

Conditional-execution unit for the multicycle ARM controller. It consumes the raw enables produced by the instruction decoder and main FSM: FlagW, PCS, NextPC, RegW, MemW and IRWrite. It evaluates the instruction's condition field against the architectural NZCV flags, which it stores itself. It emits the gated PCWrite, RegWrite and MemWrite strobes used by the datapath, and keeps two debug counters: instructions fetched and instructions squashed by their condition.

---
 rtl/condlogic_mc.sv | 126 ++++++++++++
 tb/tb_condlogic_mc.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/condlogic_mc.sv
// condlogic_mc -- conditional-execution unit for the multicycle ARM controller.
//
// Evaluates the held instruction's condition field against the architectural
// NZCV flags (stored here), gates the FSM's write requests with the condition
// captured one cycle earlier, and keeps two wrapping debug counters.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   asynchronous active-low reset
//   Cond      in   [3:0] Instr[31:28] of the held instruction
//   ALUFlags  in   [3:0] {N,Z,C,V} from the ALU this cycle
//   FlagW     in   [1:0] [1] update N,Z ; [0] update C,V
//   PCS       in   instruction writes PC
//   NextPC    in   fetch-cycle PC increment (ungated)
//   RegW      in   register-write request
//   MemW      in   memory-write request
//   IRWrite   in   fetch strobe
//   PCWrite   out  gated PC enable
//   RegWrite  out  gated register-file write
//   MemWrite  out  gated memory write
//   CondEx    out  combinational condition result
//   Flags     out  [3:0] architectural {N,Z,C,V}
//   FetchCnt  out  [CNT_W-1:0] fetches since reset (wraps)
//   SkipCnt   out  [CNT_W-1:0] condition-failed instructions (wraps)

module condlogic_mc #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             NextPC,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             IRWrite,
   output logic             PCWrite,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             CondEx,
   output logic [3:0]       Flags,
   output logic [CNT_W-1:0] FetchCnt,
   output logic [CNT_W-1:0] SkipCnt
);

   logic [3:0]       flags_reg;
   logic             cond_ex_delayed_reg;
   logic             dec_pend_reg;
   logic [CNT_W-1:0] fetch_cnt_reg;
   logic [CNT_W-1:0] skip_cnt_reg;
   logic             cond_ex;

   logic flag_n, flag_z, flag_c, flag_v, ge;
   assign flag_n = flags_reg[3];
   assign flag_z = flags_reg[2];
   assign flag_c = flags_reg[1];
   assign flag_v = flags_reg[0];
   assign ge     = (flag_n == flag_v);

   always_comb begin
      cond_ex = 1'b1;
      case (Cond)
         4'b0000: cond_ex = flag_z;
         4'b0001: cond_ex = ~flag_z;
         4'b0010: cond_ex = flag_c;
         4'b0011: cond_ex = ~flag_c;
         4'b0100: cond_ex = flag_n;
         4'b0101: cond_ex = ~flag_n;
         4'b0110: cond_ex = flag_v;
         4'b0111: cond_ex = ~flag_v;
         4'b1000: cond_ex = flag_c & ~flag_z;
         4'b1001: cond_ex = ~flag_c | flag_z;
         4'b1010: cond_ex = ge;
         4'b1011: cond_ex = ~ge;
         4'b1100: cond_ex = ~flag_z & ge;
         4'b1101: cond_ex = flag_z | ~ge;
         default: cond_ex = 1'b1;   // AL and 1111 both unconditional
      endcase
   end

   // Flag halves update independently; a failed condition blocks both.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flags_reg <= 4'b0000;
      end else begin
         if (FlagW[1] && cond_ex) flags_reg[3:2] <= ALUFlags[3:2];
         if (FlagW[0] && cond_ex) flags_reg[1:0] <= ALUFlags[1:0];
      end
   end

   // The decode-cycle condition is held here so later multicycle states keep
   // using it even after the same instruction has rewritten the flags.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cond_ex_delayed_reg <= 1'b0;
         dec_pend_reg        <= 1'b0;
      end else begin
         cond_ex_delayed_reg <= cond_ex;
         dec_pend_reg        <= IRWrite;   // back-to-back fetches keep it set
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_cnt_reg <= '0;
         skip_cnt_reg  <= '0;
      end else begin
         if (IRWrite)
            fetch_cnt_reg <= fetch_cnt_reg + 1'b1;
         if (dec_pend_reg && !cond_ex)
            skip_cnt_reg <= skip_cnt_reg + 1'b1;
      end
   end

   // NextPC is deliberately ungated: the fetch increment happens regardless.
   assign PCWrite  = (PCS & cond_ex_delayed_reg) | NextPC;
   assign RegWrite = RegW & cond_ex_delayed_reg;
   assign MemWrite = MemW & cond_ex_delayed_reg;
   assign CondEx   = cond_ex;
   assign Flags    = flags_reg;
   assign FetchCnt = fetch_cnt_reg;
   assign SkipCnt  = skip_cnt_reg;

endmodule

// File: tb/tb_condlogic_mc.sv
// tb_condlogic_mc -- scoreboard bench for condlogic_mc.
// Expectations are queued as stimulus is applied and drained against the DUT
// outputs mid-cycle, away from the rising edge.

module tb_condlogic_mc;

   localparam int CNT_W = 16;

   localparam int SEL_CONDEX   = 0;
   localparam int SEL_FLAGS    = 1;
   localparam int SEL_FETCH    = 2;
   localparam int SEL_SKIP     = 3;
   localparam int SEL_PCWRITE  = 4;
   localparam int SEL_REGWRITE = 5;
   localparam int SEL_MEMWRITE = 6;

   logic             clk;
   logic             reset;
   logic [3:0]       Cond;
   logic [3:0]       ALUFlags;
   logic [1:0]       FlagW;
   logic             PCS, NextPC, RegW, MemW, IRWrite;
   logic             PCWrite, RegWrite, MemWrite, CondEx;
   logic [3:0]       Flags;
   logic [CNT_W-1:0] FetchCnt, SkipCnt;

   condlogic_mc #(.CNT_W(CNT_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .Cond     (Cond),
      .ALUFlags (ALUFlags),
      .FlagW    (FlagW),
      .PCS      (PCS),
      .NextPC   (NextPC),
      .RegW     (RegW),
      .MemW     (MemW),
      .IRWrite  (IRWrite),
      .PCWrite  (PCWrite),
      .RegWrite (RegWrite),
      .MemWrite (MemWrite),
      .CondEx   (CondEx),
      .Flags    (Flags),
      .FetchCnt (FetchCnt),
      .SkipCnt  (SkipCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic expect_out(input string tag, input int sel, input logic [31:0] exp);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = exp;
      exp_q.push_back(e);
   endtask

   function automatic logic [31:0] observe(input int sel);
      case (sel)
         SEL_CONDEX:   return {31'd0, CondEx};
         SEL_FLAGS:    return {28'd0, Flags};
         SEL_FETCH:    return {16'd0, FetchCnt};
         SEL_SKIP:     return {16'd0, SkipCnt};
         SEL_PCWRITE:  return {31'd0, PCWrite};
         SEL_REGWRITE: return {31'd0, RegWrite};
         default:      return {31'd0, MemWrite};
      endcase
   endfunction

   // Sample settled outputs and retire every queued expectation.
   task automatic drain();
      exp_t e;
      #2;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check(e.tag, observe(e.sel), e.exp);
      end
   endtask

   // Independent reference for the condition table.
   function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cy;
         4'h3: return !cy;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cy && !z;
         4'h9: return !cy || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         default: return 1'b1;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_flags(input logic [3:0] f);
      Cond = 4'hE; FlagW = 2'b11; ALUFlags = f;
      step();
      FlagW = 2'b00; ALUFlags = 4'h0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   initial begin
      reset = 1'b0; Cond = 4'h0; ALUFlags = 4'h0; FlagW = 2'b00;
      PCS = 0; NextPC = 0; RegW = 0; MemW = 0; IRWrite = 0;

      // Reset held, all inputs zero
      step(); step();
      expect_out("rst_flags", SEL_FLAGS, 32'h0);
      expect_out("rst_fetch", SEL_FETCH, 32'h0);
      expect_out("rst_skip", SEL_SKIP, 32'h0);
      expect_out("rst_pcw", SEL_PCWRITE, 32'h0);
      expect_out("rst_regw", SEL_REGWRITE, 32'h0);
      expect_out("rst_memw", SEL_MEMWRITE, 32'h0);
      expect_out("rst_condex", SEL_CONDEX, 32'h0);   // EQ with Z=0
      drain();
      reset = 1'b1;
      step();

      // EQ true with Z=1: RegWrite passes
      set_flags(4'b0100);
      Cond = 4'h0; step(); step();
      RegW = 1'b1; PCS = 1'b1;
      expect_out("eq_regw", SEL_REGWRITE, 32'h1);
      expect_out("eq_pcw", SEL_PCWRITE, 32'h1);
      drain();
      RegW = 1'b0; PCS = 1'b0;
      // NE false: RegWrite blocked, NextPC still drives PCWrite
      Cond = 4'h1; step(); step();
      RegW = 1'b1; PCS = 1'b1;
      expect_out("ne_regw", SEL_REGWRITE, 32'h0);
      expect_out("ne_pcw_gated", SEL_PCWRITE, 32'h0);
      drain();
      NextPC = 1'b1;
      expect_out("nextpc_bypass", SEL_PCWRITE, 32'h1);
      drain();
      RegW = 1'b0; PCS = 1'b0; NextPC = 1'b0;

      // Flag update under AL, then under a failing EQ
      set_flags(4'b0000);
      Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b1001;
      step();
      FlagW = 2'b00; ALUFlags = 4'h0;
      expect_out("flagw_al", SEL_FLAGS, 32'h9);
      Cond = 4'hA;
      expect_out("ge_true", SEL_CONDEX, 32'h1);
      drain();
      Cond = 4'hB;
      expect_out("lt_false", SEL_CONDEX, 32'h0);
      drain();
      set_flags(4'b0000);
      Cond = 4'h0; FlagW = 2'b11; ALUFlags = 4'b1111;
      step();
      FlagW = 2'b00; ALUFlags = 4'h0;
      expect_out("flagw_blocked", SEL_FLAGS, 32'h0);
      drain();
      // Only the N,Z half updates
      Cond = 4'hE; FlagW = 2'b10; ALUFlags = 4'b1111;
      step();
      FlagW = 2'b00; ALUFlags = 4'h0;
      expect_out("flagw_nz_only", SEL_FLAGS, 32'hC);
      drain();

      // Full condition sweep
      for (int f = 0; f < 16; f++) begin
         set_flags(f[3:0]);
         expect_out($sformatf("sweep_flags_%0h", f), SEL_FLAGS, f);
         drain();
         for (int c = 0; c < 16; c++) begin
            Cond = c[3:0];
            expect_out($sformatf("cond_%0h_f%0h", c, f), SEL_CONDEX,
                       {31'd0, ref_cond(c[3:0], f[3:0])});
            drain();
         end
      end

      // Counters: three fetches, conditions true, false, false (Flags=0000)
      do_reset();
      for (int i = 0; i < 3; i++) begin
         IRWrite = 1'b1;
         step();
         IRWrite = 1'b0;
         Cond = (i == 0) ? 4'hE : 4'h0;
         step();
      end
      expect_out("fetch_3", SEL_FETCH, 32'd3);
      expect_out("skip_2", SEL_SKIP, 32'd2);
      drain();
      Cond = 4'hE;
      IRWrite = 1'b1;
      for (int i = 0; i < 65532; i++) step();
      expect_out("fetch_ffff", SEL_FETCH, 32'hFFFF);
      expect_out("skip_hold", SEL_SKIP, 32'd2);
      drain();
      step();
      IRWrite = 1'b0;
      expect_out("fetch_wrap", SEL_FETCH, 32'h0);
      drain();

      // Async reset mid-execute
      set_flags(4'b1111);
      Cond = 4'hE; step();
      MemW = 1'b1;
      expect_out("exec_memw", SEL_MEMWRITE, 32'h1);
      expect_out("exec_flags", SEL_FLAGS, 32'hF);
      drain();
      reset = 1'b0;
      expect_out("async_memw", SEL_MEMWRITE, 32'h0);
      expect_out("async_flags", SEL_FLAGS, 32'h0);
      expect_out("async_fetch", SEL_FETCH, 32'h0);
      expect_out("async_skip", SEL_SKIP, 32'h0);
      drain();
      step();
      reset = 1'b1;
      expect_out("post_rel_memw", SEL_MEMWRITE, 32'h0);
      drain();
      step();
      expect_out("post_edge_memw", SEL_MEMWRITE, 32'h1);
      drain();
      MemW = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
